// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv
//   Multi-cycle signed binary to 6-digit BCD converter (shift-add-3 / double
//   dabble). It processes one magnitude bit per clock and feeds the 6-digit
//   seven-segment display driver.
// Ports
//   sys_clk  in   1      system clock, rising edge
//   sys_rst  in   1      asynchronous active-high reset
//   start    in   1      conversion request, sampled only in IDLE
//   din      in   IN_W   signed two's-complement value
//   busy     out  1      high from the accept edge until the end of DONE
//   done     out  1      one-cycle pulse when bcd/sign/ovf have just updated
//   bcd      out  24     {h_hun,t_tho,tho,hun,ten,unit}, 4 bits per digit
//   sign     out  1      result is negative
//   ovf      out  1      |din| > MAX_VAL, bcd saturated to 0x999999
module bcd_seq_conv #(
  parameter int BIN_W   = 20,
  parameter int IN_W    = 21,
  parameter int MAX_VAL = 999999
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            start,
  input  logic [IN_W-1:0] din,
  output logic            busy,
  output logic            done,
  output logic [23:0]     bcd,
  output logic            sign,
  output logic            ovf
);

  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IN_W-1:0]  r_din;
  logic [BIN_W-1:0] r_mag;
  logic [23:0]      r_work;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_nxt;
  logic             r_ovf_nxt;
  logic             r_busy;
  logic             r_done;
  logic [23:0]      r_bcd;
  logic             r_sign;
  logic             r_ovf;

  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_last;
  logic [IN_W-1:0]  w_abs;
  logic             w_sat;
  logic [23:0]      w_work_corr;
  logic [23:0]      w_work_shift;
  logic [BIN_W-1:0] w_mag_shift;

  // Add 3 to every BCD nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [23:0] add3_nibbles(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  nib;
    r = 24'd0;
    for (int i = 0; i < 6; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = nib + 4'd3;
      end else begin
        r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  // Magnitude in the full input width so the most negative value does not wrap.
  assign w_abs = r_din[IN_W-1] ? (~r_din + {{(IN_W-1){1'b0}}, 1'b1}) : r_din;
  assign w_sat = (w_abs > IN_W'(MAX_VAL));

  // {work, mag} is shifted as one register: the top magnitude bit enters the unit nibble.
  assign w_work_corr  = add3_nibbles(r_work);
  assign w_work_shift = {w_work_corr[22:0], r_mag[BIN_W-1]};
  assign w_mag_shift  = {r_mag[BIN_W-2:0], 1'b0};
  assign w_last       = (r_cnt == CNT_W'(BIN_W - 1));

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the busy/done flags, registered below.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = start;
        w_done_nxt = 1'b0;
      end
      S_LOAD: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b0;
      end
      S_SHIFT: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = w_last;
      end
      S_DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Registered status flags.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Conversion datapath; results are published only on the final shift.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_din      <= {IN_W{1'b0}};
      r_mag      <= {BIN_W{1'b0}};
      r_work     <= 24'd0;
      r_cnt      <= {CNT_W{1'b0}};
      r_sign_nxt <= 1'b0;
      r_ovf_nxt  <= 1'b0;
      r_bcd      <= 24'd0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_din <= din;
          end
        end
        S_LOAD: begin
          r_mag      <= w_sat ? BIN_W'(MAX_VAL) : w_abs[BIN_W-1:0];
          r_ovf_nxt  <= w_sat;
          r_sign_nxt <= r_din[IN_W-1];
          r_work     <= 24'd0;
          r_cnt      <= {CNT_W{1'b0}};
        end
        S_SHIFT: begin
          r_work <= w_work_shift;
          r_mag  <= w_mag_shift;
          r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_bcd  <= w_work_shift;
            r_sign <= r_sign_nxt;
            r_ovf  <= r_ovf_nxt;
          end
        end
        S_DONE: begin
          r_cnt <= {CNT_W{1'b0}};
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign sign = r_sign;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed self-checking bench for bcd_seq_conv.
module tb_bcd_seq_conv;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic [20:0] din;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        sign;
  logic        ovf;

  int n_assert;
  int n_fail;

  bcd_seq_conv dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .sign    (sign),
    .ovf     (ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a conversion, wait for done, check latency and results.
  task automatic convert(input string tag, input logic [20:0] v,
                         input logic [23:0] e_bcd, input logic e_sign, input logic e_ovf);
    int n;
    @(negedge sys_clk);
    start = 1'b1;
    din   = v;
    @(negedge sys_clk);
    start = 1'b0;
    din   = 21'd0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_latency"}, n, 32'd21);
    check({tag, "_bcd"}, {8'd0, bcd}, {8'd0, e_bcd});
    check({tag, "_sign"}, {31'd0, sign}, {31'd0, e_sign});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    @(negedge sys_clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    logic prev_done;
    n_assert  = 0;
    n_fail    = 0;
    start     = 1'b0;
    din       = 21'd0;
    sys_rst   = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {8'd0, bcd}, 32'd0);
    check("rst_sign", {31'd0, sign}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    convert("p123456", 21'd123456, 24'h123456, 1'b0, 1'b0);
    convert("m42", 21'h1FFFD6, 24'h000042, 1'b1, 1'b0);
    convert("zero", 21'd0, 24'h000000, 1'b0, 1'b0);
    convert("pmax", 21'd1048575, 24'h999999, 1'b0, 1'b1);
    convert("mmin", 21'h100000, 24'h999999, 1'b1, 1'b1);
    convert("p999999", 21'd999999, 24'h999999, 1'b0, 1'b0);
    convert("p1000000", 21'd1000000, 24'h999999, 1'b0, 1'b1);
    convert("p1", 21'd1, 24'h000001, 1'b0, 1'b0);

    // Outputs hold while idle.
    repeat (5) @(negedge sys_clk);
    check("hold_bcd", {8'd0, bcd}, {8'd0, 24'h000001});

    // Start while busy is ignored.
    @(negedge sys_clk);
    start = 1'b1;
    din   = 21'd5;
    @(negedge sys_clk);
    start = 1'b0;
    din   = 21'd0;
    repeat (11) @(negedge sys_clk);
    start = 1'b1;
    din   = 21'd7;
    @(negedge sys_clk);
    start = 1'b0;
    din   = 21'd0;
    ndone     = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (prev_done) begin
        check("ign_busy_fall", {31'd0, busy}, 32'd0);
      end
      if (done === 1'b1) begin
        ndone++;
        check("ign_bcd", {8'd0, bcd}, {8'd0, 24'h000005});
      end
      prev_done = done;
    end
    check("ign_done_count", ndone, 32'd1);

    // Asynchronous reset mid-conversion (previous result 5 still shown).
    @(negedge sys_clk);
    start = 1'b1;
    din   = 21'd123;
    @(negedge sys_clk);
    start = 1'b0;
    din   = 21'd0;
    repeat (9) @(negedge sys_clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    sys_rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_bcd", {8'd0, bcd}, 32'd0);
    check("arst_sign", {31'd0, sign}, 32'd0);
    check("arst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    convert("m999", 21'h1FFC19, 24'h000999, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
